// File: rtl/mod_multiply.sv
// Sequential modular multiplier: product = (a * b) mod p, MSB-first
// interleaved double-and-add, one multiplier bit per clock.
package elliptic_curve_structs;
  typedef struct packed {
    logic [255:0] p;
  } curve_params_t;

  // secp256k1 field prime
  localparam curve_params_t params = '{
    p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
  };
endpackage

module mod_multiply #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH:0] P_EXT = (WIDTH+1)'(elliptic_curve_structs::params.p);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_product;

  logic             w_bit;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_acc_next;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // One double-and-add step; both partial sums stay below 2p, so a single
  // conditional subtract per stage keeps the accumulator fully reduced.
  always_comb begin
    w_bit      = r_b[r_cnt];
    w_dbl      = {r_acc, 1'b0};
    w_dbl_red  = (w_dbl >= P_EXT) ? (w_dbl - P_EXT) : w_dbl;
    w_add      = w_dbl_red + (w_bit ? {1'b0, r_a} : '0);
    w_acc_next = WIDTH'((w_add >= P_EXT) ? (w_add - P_EXT) : w_add);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= CW'(WIDTH - 1);
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt != '0) r_cnt     <= r_cnt - CW'(1);
          else             r_product <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_mod_multiply.sv
// Self-checking bench for mod_multiply: directed vector table, random jobs
// against an arbitrary-precision (a*b)%p model, and multi-cycle sequences.
module tb_mod_multiply;

  localparam int unsigned W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int LAT     = W + 1;
  localparam int PERIOD  = W + 2;
  localparam int TIMEOUT = 400;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  int checks = 0;
  int errors = 0;

  mod_multiply #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] t;
    t = (2*W)'(x) * (2*W)'(y);
    return W'(t % (2*W)'(P));
  endfunction

  function automatic logic [W-1:0] rand_below_p();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    if (v >= P) v = v - P;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Run one job from an IDLE cycle; returns product, latency (edges from
  // acceptance up to done) and number of cycles busy was seen high.
  task automatic run_job(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] prod, output int lat, output int nbusy);
    a = xa; b = xb; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    a = ~xa; b = ~xb;
    lat = 1; nbusy = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) nbusy++;
      @(posedge Clk); #1;
      lat++;
    end
    prod = product;
  endtask

  vec_t         vecs[$];
  logic [W-1:0] got;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] first_exp;
  logic [W-1:0] last;
  int           lat;
  int           nbusy;
  int           ndone;
  int           bad;

  initial begin
    Reset = 1'b1; start = 1'b0; a = '0; b = '0;
    vecs.push_back('{a: 256'd3,   b: 256'd5,   exp: 256'd15});
    vecs.push_back('{a: P - 1,    b: P - 1,    exp: 256'd1});
    vecs.push_back('{a: P - 1,    b: 256'd2,   exp: P - 2});
    vecs.push_back('{a: 256'd0,   b: P - 1,    exp: 256'd0});
    vecs.push_back('{a: 256'd7,   b: 256'd9,   exp: 256'd63});
    vecs.push_back('{a: P - 1,    b: 256'd1,   exp: P - 1});
    vecs.push_back('{a: 256'd1 << 255, b: 256'd2, exp: 256'h1_000003D1});
    vecs.push_back('{a: 256'd1 << 128, b: 256'd1 << 128, exp: 256'h1_000003D1});

    repeat (3) @(posedge Clk);
    #1;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_val("reset_product", product, '0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_job(vecs[i].a, vecs[i].b, got, lat, nbusy);
      check_val($sformatf("vec%0d_product", i), got, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, LAT);
      if (i == 0) check_int("vec0_busy_cycles", nbusy, W);
      @(posedge Clk); #1;
      if (i == 0) begin
        check_int("done_one_cycle", int'(done), 0);
        check_int("idle_busy", int'(busy), 0);
      end
    end

    // Identity / zero rules on random x
    for (int i = 0; i < 20; i++) begin
      x = rand_below_p();
      run_job(x, 256'd1, got, lat, nbusy);
      check_val($sformatf("rand%0d_x_times_1", i), got, x);
      @(posedge Clk); #1;
      run_job(x, 256'd0, got, lat, nbusy);
      check_val($sformatf("rand%0d_x_times_0", i), got, '0);
      @(posedge Clk); #1;
    end

    // Random operands against the model
    for (int i = 0; i < 30; i++) begin
      x = rand_below_p();
      y = rand_below_p();
      run_job(x, y, got, lat, nbusy);
      check_val($sformatf("rand%0d_model", i), got, ref_mul(x, y));
      check_int($sformatf("rand%0d_latency", i), lat, LAT);
      @(posedge Clk); #1;
    end

    // start pulses during RUN and at the done edge are ignored
    x = rand_below_p();
    y = rand_below_p();
    first_exp = ref_mul(x, y);
    a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 270; c++) begin
      start = (c == 50 || c == 256) ? 1'b1 : 1'b0;
      a = 256'd11; b = 256'd13;
      if (done) begin
        ndone++;
        check_int("ignore_done_cycle", c, LAT);
        check_val("ignore_product", product, first_exp);
      end
      @(posedge Clk); #1;
    end
    start = 1'b0;
    check_int("ignore_done_count", ndone, 1);
    check_val("ignore_product_held", product, first_exp);
    check_int("ignore_back_idle", int'(busy), 0);

    // Asynchronous reset mid-RUN
    a = 256'd12345; b = 256'd6789; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (99) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_done", int'(done), 0);
    check_val("midreset_product", product, '0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    run_job(256'd7, 256'd9, got, lat, nbusy);
    check_val("after_reset_product", got, 256'd63);
    check_int("after_reset_latency", lat, LAT);
    @(posedge Clk); #1;

    // start held high across three jobs
    begin
      logic [W-1:0] ja[3];
      logic [W-1:0] jb[3];
      int k;
      int c;
      int last_c;
      for (int j = 0; j < 3; j++) begin
        ja[j] = rand_below_p();
        jb[j] = rand_below_p();
      end
      k = 0; c = 0; last_c = 0; bad = 0; last = '0;
      a = ja[0]; b = jb[0]; start = 1'b1;
      @(posedge Clk); #1;
      c = 1;
      while (k < 3 && c < 4 * PERIOD) begin
        if (done) begin
          check_val($sformatf("hold_job%0d_product", k), product, ref_mul(ja[k], jb[k]));
          check_int($sformatf("hold_job%0d_interval", k), c - last_c, (k == 0) ? LAT : PERIOD);
          last = product;
          last_c = c;
          k++;
          if (k < 3) begin
            a = ja[k]; b = jb[k];
          end else begin
            start = 1'b0;
          end
        end else if (k > 0 && product !== last) begin
          bad++;
        end
        @(posedge Clk); #1;
        c++;
      end
      start = 1'b0;
      check_int("hold_jobs_completed", k, 3);
      check_int("hold_product_stable", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
